instr_fetch_unit: RTL and testbench
===================================

# instr_fetch_unit

Instruction fetch stage for the MIPS single-cycle processor: owns the program counter, fetches one 32-bit word per instruction from instruction memory over a ready/req handshake, and presents the latched instruction and its decoded opcode/funct fields to the control unit. It closes the loop by computing the next PC from the control unit's `branch`/`jump` outputs and the ALU `zero` flag, and holds the core in a defined state while memory stalls.

## Interface
Parameters:
- `RESET_PC`, default 32'h0000_0000: PC after reset; must be word aligned (bits [1:0] = 0).

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `reset_n`  in  1  synchronous, active-low reset, sampled on the rising edge of `clk`.
- `imem_req`  out  1  fetch request to instruction memory.
- `imem_addr`  out  32  word-aligned fetch address; equals `pc`.
- `imem_rdata`  in  32  instruction word; valid when `imem_ready` = 1.
- `imem_ready`  in  1  memory accepts the request and returns data in the same cycle.
- `branch`  in  1  control unit branch decision for the current instruction.
- `zero`  in  1  ALU zero flag for the current instruction.
- `jump`  in  1  control unit jump decision for the current instruction.
- `instr_valid`  out  1  one-cycle strobe: `instr` is valid and executes this cycle.
- `instr`  out  32  latched instruction word.
- `op`  out  6  `instr[31:26]`, to the control unit.
- `funct`  out  6  `instr[5:0]`, to the control unit.
- `pc`  out  32  address of the current instruction.
- `pc_plus4`  out  32  `pc + 4`, modulo 2^32.

## Operation
- FSM states: FETCH, EXEC, plus HALT when `FETCH_HALT_EN` is defined.
- FETCH: `imem_req` = 1 and `imem_addr` = `pc`, both held stable until `imem_ready` = 1. On a cycle with `imem_req` and `imem_ready` both 1, `imem_rdata` is captured into `instr` and the FSM goes to EXEC.
- EXEC: lasts exactly one cycle. `instr_valid` = 1 and `imem_req` = 0. `branch`, `zero` and `jump` are sampled in this cycle. At the end of the cycle `pc` is loaded with next_pc and the FSM returns to FETCH.
- next_pc, in priority order:
  - if `jump`: {`pc_plus4[31:28]`, `instr[25:0]`, 2'b00};
  - else if `branch` & `zero`: `pc_plus4` + (sign-extended `instr[15:0]` << 2), 32-bit, wrap-around;
  - else: `pc_plus4`.
- `branch`/`jump`/`zero` are ignored outside EXEC, including X values.
- `pc[1:0]` is always 0. `pc_plus4` at `pc` = 32'hFFFF_FFFC wraps to 0.
- `instr`, `op` and `funct` hold their last captured value through FETCH.

## Timing
- Reset (`reset_n` = 0 at an edge) forces: `pc` = `RESET_PC`, state = FETCH, `instr` = 0, `instr_valid` = 0. `imem_req` is 1 in the first cycle after the reset edge.
- Reset mid-FETCH abandons the outstanding request. No data is captured in the reset cycle, and the new request uses `RESET_PC`.
- Reset asserted during EXEC: `pc` does not take next_pc.
- Minimum throughput is 2 cycles per instruction (FETCH with immediate ready, then EXEC). Each memory wait cycle adds 1 cycle.
- Fetch-to-use latency: `instr_valid` rises in the cycle after the accepting FETCH cycle.

## Configuration
- `FETCH_HALT_EN` defined:
  - a captured instruction with `op` = 6'b111111 still gets its one EXEC cycle (`instr_valid` = 1);
  - the FSM then enters HALT and `pc` is not updated;
  - in HALT, `imem_req` = 0 and `instr_valid` = 0 until reset.
- `FETCH_HALT_EN` not defined: there is no HALT state, and op 6'b111111 is fetched and sequenced like any other opcode.

## Test plan
- Reset: hold `reset_n` = 0 for 3 cycles, then release -> `pc` = 0, `imem_req` = 1, `imem_addr` = 0, `instr_valid` = 0.
- Straight-line code, `imem_ready` tied to 1, `branch`/`jump` = 0 -> `imem_addr` sequence 0, 4, 8, 12 on every other cycle, with `instr_valid` toggling 0/1.
- Wait states: `imem_ready` low for 3 cycles at addr 4 -> `imem_addr` stable at 4 for 4 cycles; `instr_valid` stays 0 until the cycle after ready; `op`/`funct` match `imem_rdata`.
- Branch: beq with imm 16'hFFFE at `pc` = 8, `branch` = 1, `zero` = 1 -> next `imem_addr` = 4. Same instruction with `zero` = 0 -> next `imem_addr` = 12.
- Jump: `instr` 32'h0800_0010 at `pc` = 32'h1000_0010 with `jump` = 1 -> next `imem_addr` = 32'h1000_0040. `jump` takes priority when `branch`/`zero` are also 1.
- Reset mid-wait: assert `reset_n` = 0 while waiting at addr 8 -> the next cycle requests `RESET_PC`, with no spurious `instr_valid`. With `FETCH_HALT_EN` defined, fetch 32'hFC00_0000 -> one `instr_valid` pulse, then `imem_req` stays 0 indefinitely.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - MIPS fetch stage: PC, imem handshake, next-PC select.
// Optional HALT on op 6'b111111 when FETCH_HALT_EN is defined.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  input  logic        branch,
  input  logic        zero,
  input  logic        jump,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [5:0]  op,
  output logic [5:0]  funct,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_EXEC  = 2'd1,
    S_HALT  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] seq_pc;
  logic [31:0] branch_off;
  logic [31:0] next_pc;

  assign seq_pc     = pc_q + 32'd4;
  assign branch_off = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};

  // Control inputs only matter in EXEC, where next_pc is consumed.
  always_comb begin
    next_pc = seq_pc;
    if (jump) begin
      next_pc = {seq_pc[31:28], instr_q[25:0], 2'b00};
    end else if (branch && zero) begin
      next_pc = seq_pc + branch_off;
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    instr_d     = instr_q;
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    case (state_q)
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          instr_d = imem_rdata;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        instr_valid = 1'b1;
        pc_d        = next_pc;
        state_d     = S_FETCH;
`ifdef FETCH_HALT_EN
        if (instr_q[31:26] == 6'b111111) begin
          pc_d    = pc_q;
          state_d = S_HALT;
        end
`endif
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_FETCH;
      pc_q    <= RESET_PC;
      instr_q <= 32'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end

  assign imem_addr = pc_q;
  assign pc        = pc_q;
  assign pc_plus4  = seq_pc;
  assign instr     = instr_q;
  assign op        = instr_q[31:26];
  assign funct     = instr_q[5:0];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - directed bench with per-cycle model compare for instr_fetch_unit.
module tb_instr_fetch_unit;

  logic        clk;
  logic        reset_n;
  logic        imem_ready;
  logic        branch, zero, jump;
  logic        imem_req, instr_valid;
  logic [31:0] imem_addr, imem_rdata, instr, pc, pc_plus4;
  logic [5:0]  op, funct;

  logic        hi_req, hi_valid;
  logic [31:0] hi_addr, hi_rdata, hi_instr, hi_pc, hi_pc_plus4;
  logic [5:0]  hi_op, hi_funct;

  logic [31:0] mem [logic [31:0]];

  int n_pass  = 0;
  int n_total = 0;
  bit check_en = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return {6'd0, a[27:2]};
  endfunction

  assign imem_rdata = mem_word(imem_addr);
  assign hi_rdata   = mem_word(hi_addr);

  instr_fetch_unit u_dut (
    .clk(clk), .reset_n(reset_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_ready(imem_ready),
    .branch(branch), .zero(zero), .jump(jump),
    .instr_valid(instr_valid), .instr(instr), .op(op), .funct(funct),
    .pc(pc), .pc_plus4(pc_plus4)
  );

  instr_fetch_unit #(.RESET_PC(32'h1000_0010)) u_dut_hi (
    .clk(clk), .reset_n(reset_n),
    .imem_req(hi_req), .imem_addr(hi_addr), .imem_rdata(hi_rdata), .imem_ready(imem_ready),
    .branch(branch), .zero(zero), .jump(jump),
    .instr_valid(hi_valid), .instr(hi_instr), .op(hi_op), .funct(hi_funct),
    .pc(hi_pc), .pc_plus4(hi_pc_plus4)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Transaction-level model: an instruction is either awaiting fetch or awaiting execution.
  logic [31:0] m_pc    = 32'd0;
  logic [31:0] m_instr = 32'd0;
  bit          m_exec  = 0;
  bit          m_halt  = 0;

  function automatic logic [31:0] target(input logic [31:0] cur, input logic [31:0] ins,
                                         input logic j, input logic b, input logic z);
    logic [31:0] seq;
    int          off;
    seq = cur + 32'd4;
    if (j) return (seq & 32'hF000_0000) | ((ins & 32'h03FF_FFFF) * 4);
    if (b && z) begin
      off = int'($signed(ins[15:0])) * 4;
      return seq + 32'(off);
    end
    return seq;
  endfunction

  always @(posedge clk) begin
    if (!reset_n) begin
      m_pc    <= 32'd0;
      m_instr <= 32'd0;
      m_exec  <= 0;
      m_halt  <= 0;
    end else if (m_exec) begin
      m_exec <= 0;
`ifdef FETCH_HALT_EN
      if ((m_instr >> 26) == 32'd63) m_halt <= 1;
      else m_pc <= target(m_pc, m_instr, jump, branch, zero);
`else
      m_pc <= target(m_pc, m_instr, jump, branch, zero);
`endif
    end else if (!m_halt && imem_ready) begin
      m_instr <= mem_word(m_pc);
      m_exec  <= 1;
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      chk("m_req",    {31'd0, imem_req},    {31'd0, !m_exec && !m_halt});
      chk("m_addr",   imem_addr,            m_pc);
      chk("m_valid",  {31'd0, instr_valid}, {31'd0, m_exec});
      chk("m_instr",  instr,                m_instr);
      chk("m_op",     {26'd0, op},          m_instr >> 26);
      chk("m_funct",  {26'd0, funct},       m_instr % 64);
      chk("m_pc",     pc,                   m_pc);
      chk("m_pcp4",   pc_plus4,             m_pc + 32'd4);
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    repeat (3) step();
    reset_n = 1'b1;
  endtask

  // Starts on a FETCH cycle with imem_ready high; control inputs are junk during FETCH.
  task automatic run_instr(input logic [31:0] exp_addr, input logic b, input logic z, input logic j);
    chk("fetch_addr", imem_addr, exp_addr);
    chk("fetch_valid", {31'd0, instr_valid}, 32'd0);
    branch = 1'b1; zero = 1'b1; jump = 1'b1;
    step();
    chk("exec_valid", {31'd0, instr_valid}, 32'd1);
    chk("exec_pc", pc, exp_addr);
    branch = b; zero = z; jump = j;
    step();
  endtask

  initial begin
    mem[32'h0000_0004] = 32'h8C43_0008;
    mem[32'h0000_0008] = 32'h1000_FFFE;
    mem[32'h0000_0020] = 32'hFC00_0000;
    mem[32'h1000_0010] = 32'h0800_0010;
    reset_n = 1'b0; imem_ready = 1'b1; branch = 1'b0; zero = 1'b0; jump = 1'b0;
    @(negedge clk);
    check_en = 1;
    repeat (3) step();
    reset_n = 1'b1;
    chk("rst_pc", pc, 32'd0);
    chk("rst_req", {31'd0, imem_req}, 32'd1);
    chk("rst_addr", imem_addr, 32'd0);
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);

    for (int i = 0; i < 4; i++) run_instr(32'(4 * i), 1'b0, 1'b0, 1'b0);

    do_reset();
    run_instr(32'd0, 1'b0, 1'b0, 1'b0);
    imem_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk("wait_addr", imem_addr, 32'd4);
      chk("wait_valid", {31'd0, instr_valid}, 32'd0);
      if (k == 3) imem_ready = 1'b1;
      step();
    end
    chk("wait_exec_valid", {31'd0, instr_valid}, 32'd1);
    chk("wait_op", {26'd0, op}, 32'h23);
    chk("wait_funct", {26'd0, funct}, 32'h08);
    branch = 1'b0; zero = 1'b0; jump = 1'b0;
    step();

    run_instr(32'd8, 1'b1, 1'b1, 1'b0);
    chk("beq_taken", imem_addr, 32'd4);
    run_instr(32'd4, 1'b0, 1'b0, 1'b0);
    run_instr(32'd8, 1'b1, 1'b0, 1'b0);
    chk("beq_not_taken", imem_addr, 32'd12);

    do_reset();
    chk("hi_rst_addr", hi_addr, 32'h1000_0010);
    run_instr(32'd0, 1'b1, 1'b1, 1'b1);
    chk("jump_lo_addr", imem_addr, 32'd0);
    chk("jump_hi_addr", hi_addr, 32'h1000_0040);
    chk("jump_hi_req", {31'd0, hi_req}, 32'd1);

    do_reset();
    run_instr(32'd0, 1'b0, 1'b0, 1'b0);
    run_instr(32'd4, 1'b0, 1'b0, 1'b0);
    imem_ready = 1'b0;
    step();
    step();
    chk("midwait_addr", imem_addr, 32'd8);
    reset_n = 1'b0;
    imem_ready = 1'b1;
    step();
    reset_n = 1'b1;
    chk("midwait_rst_addr", imem_addr, 32'd0);
    chk("midwait_rst_req", {31'd0, imem_req}, 32'd1);
    chk("midwait_rst_valid", {31'd0, instr_valid}, 32'd0);
    step();
    chk("midwait_exec_pc", pc, 32'd0);
    chk("midwait_exec_instr", instr, 32'd0);
    step();

    do_reset();
    for (int i = 0; i < 8; i++) run_instr(32'(4 * i), 1'b0, 1'b0, 1'b0);
    chk("halt_fetch_addr", imem_addr, 32'h20);
    step();
    chk("halt_exec_valid", {31'd0, instr_valid}, 32'd1);
    chk("halt_exec_op", {26'd0, op}, 32'h3F);
    step();
`ifdef FETCH_HALT_EN
    for (int k = 0; k < 6; k++) begin
      chk("halt_req", {31'd0, imem_req}, 32'd0);
      chk("halt_valid", {31'd0, instr_valid}, 32'd0);
      step();
    end
`else
    chk("nohalt_addr", imem_addr, 32'h24);
    chk("nohalt_req", {31'd0, imem_req}, 32'd1);
    step();
`endif
    check_en = 0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
